// File: rtl/mat_switch_pkg.sv
// Shared types for the mailbox switch: 32-bit words, lane vectors, and port states.
package mat_switch_pkg;

  localparam int WORD_BITS = 32;
  localparam int DEF_LANES = 16;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef word_t [DEF_LANES-1:0] lanes_t;

  typedef enum logic {
    PORT_IDLE = 1'b0,
    PORT_ACK  = 1'b1
  } port_state_e;

  // Indices outside the populated core range never hit a slot.
  function automatic logic idx_valid(input int idx, input int size);
    return idx < size;
  endfunction

endpackage

// File: rtl/mat_switch_slot.sv
// One (src,dst) mailbox slot: a write fills it and a read empties it.
// The write is applied only while the slot is empty, and the read only while it is full.
module mat_switch_slot
  import mat_switch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  word_t [WIDTH-1:0]   wr_data,
  input  logic                rd_en,
  output logic                vld,
  output word_t [WIDTH-1:0]   dat
);

  logic              vld_q, vld_d;
  word_t [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = wr_en | (vld_q & ~rd_en);
    dat_d = wr_en ? wr_data : dat_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/mat_switch.sv
// Core-to-core mailbox crossbar with one slot per (src,dst) pair; send_ok and recv_ready arrive one cycle after acceptance.
// A send to a full slot and a receive from an empty slot both stall; the next send and receive are each delayed by one cycle, with no bypass.
module mat_switch
  import mat_switch_pkg::*;
#(
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SWITCH_WIDTH          = 16,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic  [SWITCH_CORE_SIZE-1:0]                           switch_send_ready,
  input  logic  [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx,
  input  word_t [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0]         switch_send_data,
  output logic  [SWITCH_CORE_SIZE-1:0]                           switch_send_ok,
  input  logic  [SWITCH_CORE_SIZE-1:0]                           switch_recv_request,
  input  logic  [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] switch_recv_core_idx,
  output logic  [SWITCH_CORE_SIZE-1:0]                           switch_recv_ready,
  output word_t [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0]         switch_recv_data,
  output logic                                                   switch_idle
);

  localparam int C = SWITCH_CORE_SIZE;
  localparam int W = SWITCH_WIDTH;

  // Slot arrays are indexed [src][dst].
  logic  [C-1:0][C-1:0]        slot_vld;
  word_t [C-1:0][C-1:0][W-1:0] slot_dat;
  logic  [C-1:0][C-1:0]        slot_wr;
  logic  [C-1:0][C-1:0]        slot_rd;

  port_state_e          send_state_q [C];
  port_state_e          send_state_d [C];
  port_state_e          recv_state_q [C];
  port_state_e          recv_state_d [C];
  word_t [C-1:0][W-1:0] recv_data_q, recv_data_d;

  always_comb begin
    slot_wr     = '0;
    slot_rd     = '0;
    recv_data_d = recv_data_q;
    for (int i = 0; i < C; i++) begin
      send_state_d[i] = PORT_IDLE;
      recv_state_d[i] = PORT_IDLE;
    end

    for (int i = 0; i < C; i++) begin
      if (send_state_q[i] == PORT_IDLE && switch_send_ready[i] &&
          idx_valid(int'(switch_send_core_idx[i]), C) &&
          !slot_vld[i][switch_send_core_idx[i]]) begin
        slot_wr[i][switch_send_core_idx[i]] = 1'b1;
        send_state_d[i]                     = PORT_ACK;
      end
    end

    // Only the pre-edge valid bit is consulted, so a slot filled this edge is read next edge.
    for (int j = 0; j < C; j++) begin
      if (recv_state_q[j] == PORT_IDLE && switch_recv_request[j] &&
          idx_valid(int'(switch_recv_core_idx[j]), C) &&
          slot_vld[switch_recv_core_idx[j]][j]) begin
        slot_rd[switch_recv_core_idx[j]][j] = 1'b1;
        recv_data_d[j]                      = slot_dat[switch_recv_core_idx[j]][j];
        recv_state_d[j]                     = PORT_ACK;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < C; i++) begin
        send_state_q[i] <= PORT_IDLE;
        recv_state_q[i] <= PORT_IDLE;
      end
      recv_data_q <= '0;
    end else begin
      for (int i = 0; i < C; i++) begin
        send_state_q[i] <= send_state_d[i];
        recv_state_q[i] <= recv_state_d[i];
      end
      recv_data_q <= recv_data_d;
    end
  end

  for (genvar s = 0; s < C; s++) begin : g_src
    for (genvar d = 0; d < C; d++) begin : g_dst
      mat_switch_slot #(.WIDTH(W)) u_slot (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (slot_wr[s][d]),
        .wr_data (switch_send_data[s]),
        .rd_en   (slot_rd[s][d]),
        .vld     (slot_vld[s][d]),
        .dat     (slot_dat[s][d])
      );
    end
  end

  always_comb begin
    for (int i = 0; i < C; i++) begin
      switch_send_ok[i]    = (send_state_q[i] == PORT_ACK);
      switch_recv_ready[i] = (recv_state_q[i] == PORT_ACK);
    end
  end

  assign switch_recv_data = recv_data_q;
  assign switch_idle      = ~|slot_vld;

endmodule

// File: tb/tb_mat_switch.sv
// Directed checks of the mailbox switch: single transfers from a vector table, then stall, wait, reset and all-port sequences.
module tb_mat_switch;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [3:0]            send_ready;
  logic [3:0][1:0]       send_idx;
  logic [3:0][15:0][31:0] send_data;
  logic [3:0]            send_ok;
  logic [3:0]            recv_request;
  logic [3:0][1:0]       recv_idx;
  logic [3:0]            recv_ready;
  logic [3:0][15:0][31:0] recv_data;
  logic                  idle;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int          src;
    int          dst;
    logic [31:0] val;
    logic [31:0] exp_dat;
  } vec_t;

  mat_switch dut (
    .clock                (clock),
    .reset                (reset),
    .switch_send_ready    (send_ready),
    .switch_send_core_idx (send_idx),
    .switch_send_data     (send_data),
    .switch_send_ok       (send_ok),
    .switch_recv_request  (recv_request),
    .switch_recv_core_idx (recv_idx),
    .switch_recv_ready    (recv_ready),
    .switch_recv_data     (recv_data),
    .switch_idle          (idle)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Returns the first lane that differs from v, else lane 0.
  function automatic logic [31:0] lane_val(input logic [15:0][31:0] d, input logic [31:0] v);
    for (int l = 0; l < 16; l++)
      if (d[l] !== v) return d[l];
    return d[0];
  endfunction

  task automatic set_send(input int s, input int d, input logic [31:0] v);
    send_idx[s] = 2'(d);
    for (int l = 0; l < 16; l++) send_data[s][l] = v;
  endtask

  vec_t vecs [5];
  logic [31:0] ring_val [4];
  logic [31:0] ring_exp [4];

  initial begin
    vecs[0] = '{src: 0, dst: 2, val: 32'h3F800000, exp_dat: 32'h3F800000};
    vecs[1] = '{src: 2, dst: 2, val: 32'hBF800000, exp_dat: 32'hBF800000};
    vecs[2] = '{src: 3, dst: 0, val: 32'hC0490FDB, exp_dat: 32'hC0490FDB};
    vecs[3] = '{src: 1, dst: 3, val: 32'h40000000, exp_dat: 32'h40000000};
    vecs[4] = '{src: 0, dst: 1, val: 32'h3FC00000, exp_dat: 32'h3FC00000};
    ring_val = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    ring_exp = '{32'h40800000, 32'h3F800000, 32'h40000000, 32'h40400000};

    reset = 1'b1;
    send_ready = '0; send_idx = '0; send_data = '0;
    recv_request = '0; recv_idx = '0;
    tick();
    tick();
    check("reset send_ok", 32'(send_ok), 32'h0);
    check("reset recv_ready", 32'(recv_ready), 32'h0);
    check_bit("reset idle", idle, 1'b1);
    for (int j = 0; j < 4; j++)
      check($sformatf("reset recv_data[%0d]", j), lane_val(recv_data[j], 32'h0), 32'h0);
    reset = 1'b0;
    tick();

    // Single transfers: send and receive requested together, delivery one edge after acceptance.
    for (int k = 0; k < 5; k++) begin
      set_send(vecs[k].src, vecs[k].dst, vecs[k].val);
      send_ready[vecs[k].src] = 1'b1;
      recv_idx[vecs[k].dst] = 2'(vecs[k].src);
      recv_request[vecs[k].dst] = 1'b1;
      tick();
      check_bit($sformatf("v%0d send_ok", k), send_ok[vecs[k].src], 1'b1);
      check_bit($sformatf("v%0d early recv_ready", k), recv_ready[vecs[k].dst], 1'b0);
      check_bit($sformatf("v%0d idle busy", k), idle, 1'b0);
      send_ready[vecs[k].src] = 1'b0;
      tick();
      check_bit($sformatf("v%0d send_ok one cycle", k), send_ok[vecs[k].src], 1'b0);
      check_bit($sformatf("v%0d recv_ready", k), recv_ready[vecs[k].dst], 1'b1);
      check($sformatf("v%0d recv_data", k), lane_val(recv_data[vecs[k].dst], vecs[k].exp_dat), vecs[k].exp_dat);
      recv_request[vecs[k].dst] = 1'b0;
      tick();
      check_bit($sformatf("v%0d recv_ready one cycle", k), recv_ready[vecs[k].dst], 1'b0);
      check_bit($sformatf("v%0d idle after", k), idle, 1'b1);
      check($sformatf("v%0d recv_data hold", k), lane_val(recv_data[vecs[k].dst], vecs[k].exp_dat), vecs[k].exp_dat);
    end

    // Back-to-back send into a full slot stalls until the receiver drains it.
    set_send(1, 3, 32'h40000000);
    send_ready[1] = 1'b1;
    tick();
    check_bit("b2b first ok", send_ok[1], 1'b1);
    tick();
    check_bit("b2b ack drop", send_ok[1], 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_bit($sformatf("b2b stall %0d", c), send_ok[1], 1'b0);
    end
    check_bit("b2b idle busy", idle, 1'b0);
    recv_idx[3] = 2'd1;
    recv_request[3] = 1'b1;
    tick();
    check_bit("b2b recv ready", recv_ready[3], 1'b1);
    check_bit("b2b no ok on consume edge", send_ok[1], 1'b0);
    check("b2b recv data", lane_val(recv_data[3], 32'h40000000), 32'h40000000);
    recv_request[3] = 1'b0;
    tick();
    check_bit("b2b second ok", send_ok[1], 1'b1);
    check_bit("b2b recv single pulse", recv_ready[3], 1'b0);
    send_ready[1] = 1'b0;
    recv_request[3] = 1'b1;
    tick();
    check_bit("b2b drain ready", recv_ready[3], 1'b1);
    check("b2b drain data", lane_val(recv_data[3], 32'h40000000), 32'h40000000);
    recv_request[3] = 1'b0;
    tick();
    check_bit("b2b idle after", idle, 1'b1);

    // Receiver waits on an empty slot until the sender fills it.
    recv_idx[3] = 2'd0;
    recv_request[3] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_bit($sformatf("wait recv_ready %0d", c), recv_ready[3], 1'b0);
    end
    set_send(0, 3, 32'h40400000);
    send_ready[0] = 1'b1;
    tick();
    check_bit("wait send_ok", send_ok[0], 1'b1);
    check_bit("wait no bypass", recv_ready[3], 1'b0);
    send_ready[0] = 1'b0;
    tick();
    check_bit("wait recv_ready", recv_ready[3], 1'b1);
    check("wait recv_data", lane_val(recv_data[3], 32'h40400000), 32'h40400000);
    recv_request[3] = 1'b0;
    tick();
    check_bit("wait idle", idle, 1'b1);

    // Reset lands on the edge that would have delivered core0 -> core1.
    set_send(0, 1, 32'h3F000000);
    send_ready[0] = 1'b1;
    recv_idx[1] = 2'd0;
    recv_request[1] = 1'b1;
    tick();
    check_bit("rst accept ok", send_ok[0], 1'b1);
    check_bit("rst slot full", idle, 1'b0);
    send_ready[0] = 1'b0;
    reset = 1'b1;
    tick();
    check_bit("rst no send_ok", send_ok[0], 1'b0);
    check_bit("rst no recv_ready", recv_ready[1], 1'b0);
    check_bit("rst idle", idle, 1'b1);
    check("rst recv_data cleared", lane_val(recv_data[1], 32'h0), 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_bit($sformatf("rst recv waits %0d", c), recv_ready[1], 1'b0);
    end
    recv_request[1] = 1'b0;

    // All four cores send to their neighbour and receive at once.
    for (int i = 0; i < 4; i++) begin
      set_send(i, (i + 1) % 4, ring_val[i]);
      recv_idx[i] = 2'((i + 3) % 4);
    end
    send_ready = 4'hF;
    recv_request = 4'hF;
    tick();
    check("ring send_ok", 32'(send_ok), 32'hF);
    check("ring early recv_ready", 32'(recv_ready), 32'h0);
    send_ready = '0;
    tick();
    check("ring recv_ready", 32'(recv_ready), 32'hF);
    for (int j = 0; j < 4; j++)
      check($sformatf("ring recv_data[%0d]", j), lane_val(recv_data[j], ring_exp[j]), ring_exp[j]);
    recv_request = '0;
    tick();
    check_bit("ring idle", idle, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mat_switch.md
MAT_SWITCH -- requirements
Module: mat_switch

Interface
REQ-001 SHALL have parameter SWITCH_CORE_SIZE, default 4, number of core ports.
REQ-002 SHALL have parameter SWITCH_WIDTH, default 16, 32-bit lanes per message.
REQ-003 SHALL have parameter SWITCH_CORE_ADDR_SIZE, default $clog2(SWITCH_CORE_SIZE), core index width.
REQ-004 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port switch_send_ready  in  [CORE]  per source core: send request.
REQ-007 SHALL have port switch_send_core_idx  in  [CORE][ADDR]  per source core: destination index.
REQ-008 SHALL have port switch_send_data  in  [CORE][WIDTH][32]  per source core: IEEE-754 single lanes.
REQ-009 SHALL have port switch_send_ok  out  [CORE]  per source core: one-cycle accept pulse.
REQ-010 SHALL have port switch_recv_request  in  [CORE]  per destination core: receive request.
REQ-011 SHALL have port switch_recv_core_idx  in  [CORE][ADDR]  per destination core: expected source index.
REQ-012 SHALL have port switch_recv_ready  out  [CORE]  per destination core: one-cycle data-valid pulse.
REQ-013 SHALL have port switch_recv_data  out  [CORE][WIDTH][32]  per destination core: delivered lanes.
REQ-014 SHALL have port switch_idle  out  1  high when no mailbox slot holds data.

Function
REQ-015 SHALL hold one mailbox slot per ordered pair (src,dst): WIDTH x 32-bit data plus a valid bit; self-send (src==dst) is legal.
REQ-016 Each port side SHALL run a two-state FSM, IDLE and ACK; ACK lasts exactly one cycle, then returns to IDLE.
REQ-017 Send: in IDLE with send_ready[i]=1 and slot[i][dst] invalid at an edge, SHALL capture data, set valid, enter ACK; send_ok[i]=1 during the following cycle only.
REQ-018 Send to a valid slot SHALL stall: send_ok[i] stays 0 and no state changes; the core holds send_ready, index and data stable until send_ok.
REQ-019 Recv: in IDLE with recv_request[j]=1 and slot[src][j] valid at an edge, SHALL copy data to recv_data[j], clear valid, enter ACK; recv_ready[j]=1 during the following cycle only.
REQ-020 Recv from an invalid slot SHALL wait with recv_ready[j]=0 until the slot becomes valid.
REQ-021 A port in ACK SHALL ignore its request that cycle; no double accept.
REQ-022 recv_data[j] SHALL hold its last delivered value until the next delivery.
REQ-023 No bypass: send and recv on the same empty slot in one cycle -> send accepted, recv served at the earliest edge after valid is set; minimum send-accept-edge to recv_ready latency is 2 cycles.
REQ-024 No bypass: recv consuming and send targeting the same full slot in one cycle -> recv served, send accepted no earlier than the next edge.
REQ-025 Each slot has one writer and one reader, so no arbitration SHALL exist; all ports operate independently and concurrently.
REQ-026 Requests whose index is >= SWITCH_CORE_SIZE SHALL be ignored (never acknowledged).
REQ-027 switch_idle SHALL be the combinational NOR of all slot valid bits.

Reset
REQ-028 While reset=1 at an edge, SHALL clear every valid bit, set all FSMs to IDLE, drive send_ok=0, recv_ready=0 and recv_data=0; switch_idle=1 the following cycle.
REQ-029 Reset mid-transfer SHALL discard slot contents and suppress any pending ok/ready pulse.

Structure
REQ-030 Package mat_switch_pkg SHALL hold the 32-bit word typedef, the lane-vector typedef and the IDLE/ACK port-state enum.
REQ-031 Sub-module mat_switch_slot SHALL implement one mailbox slot (write strobe, read strobe, valid, data), instantiated CORE x CORE times.

Verification
REQ-032 Core0 sends lanes all 0x3F800000 to core2; core2 requests src 0 -> send_ok[0] pulses 1 cycle; recv_ready[2] pulses 2 cycles after accept with all lanes 0x3F800000.
REQ-033 Core1 sends 0x40000000 to core3 twice back-to-back, no recv -> second send stalls; once core3 receives, second send_ok fires next edge.
REQ-034 Core3 requests src 0 with slot empty for 5 cycles, then core0 sends 0x40400000 -> recv_ready[3] low throughout wait, then delivers 0x40400000.
REQ-035 Core2 self-send 0xBF800000 then recv src 2 -> delivered intact; switch_idle returns to 1.
REQ-036 Reset asserted one cycle after accept of core0->core1 -> no send_ok, slot cleared, core1 request afterwards waits; switch_idle=1.
REQ-037 All four cores send to (i+1)%4 and receive simultaneously -> four independent deliveries, each value matching its source.
